// File: rtl/bsg_pkg.sv
// Shared types and constants for the bsg_modulator slice.
// Optional feature macro: BSG_MOD_PARITY_EN (adds an even-parity symbol after DATA).
package bsg_pkg;

  localparam logic [7:0] MIDSCALE  = 8'h80;
  localparam int         DATA_BITS = 16;
  localparam logic [3:0] BIT_FIRST = 4'd15;

`ifdef BSG_MOD_PARITY_EN
  localparam int FRAME_TICKS = 19;
`else
  localparam int FRAME_TICKS = 18;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef BSG_MOD_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_e;

endpackage

// File: rtl/bsg_word_fifo.sv
// Small word FIFO feeding the modulator; pop of an empty FIFO and push of a
// full FIFO are ignored. Storage is not reset, only the pointers and count.
module bsg_word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Word storage.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bsg_modulator.sv
// Serial amplitude modulator: frames buffered 16-bit words as
// start(0) / 16 data bits MSB first / [parity] / stop(1), one symbol per tick.
// Optional feature macro: BSG_MOD_PARITY_EN.
//
// state  | meaning
// IDLE   | output at midscale, waiting for tick with tx_en and a buffered word
// START  | emitting start symbol 0
// DATA   | emitting payload bits, bit counter counts down 15..0
// PARITY | emitting even-parity bit (macro build only)
// STOP   | emitting stop symbol 1; its ending tick raises int_flag
module bsg_modulator
  import bsg_pkg::*;
#(
  parameter logic [7:0] AMP        = 8'd100,
  parameter int         FIFO_DEPTH = 2
) (
  input  logic        SYS_CLK,
  input  logic        reset,
  input  logic        tx_en,
  input  logic        tx_tick,
  input  logic [15:0] data_in,
  input  logic        valid,
  output logic        ready,
  input  logic        int_mask,
  input  logic        int_clr,
  output logic [7:0]  out,
  output logic        int_flag,
  output logic        irq,
  output logic        busy
);

  localparam logic [7:0] LVL_HI = MIDSCALE + AMP;
  localparam logic [7:0] LVL_LO = MIDSCALE - AMP;

  state_e      state, state_n;
  logic [15:0] shreg, shreg_n;
  logic [3:0]  cnt, cnt_n;
  logic [7:0]  out_n;
  logic        pop, frame_done;
  logic [15:0] fifo_rdata;
  logic        fifo_full, fifo_empty;

  bsg_word_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (SYS_CLK),
    .reset (reset),
    .push  (valid & ready),
    .wdata (data_in),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ready = ~fifo_full;
  assign busy  = (state != ST_IDLE);
  assign irq   = int_flag & ~int_mask;

  // Next-state, shift/rotate and next output level; nothing moves without a tick.
  // The payload is rotated rather than shifted so its parity stays computable.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    cnt_n      = cnt;
    out_n      = out;
    pop        = 1'b0;
    frame_done = 1'b0;
    if (tx_tick) begin
      case (state)
        ST_IDLE: begin
          if (tx_en && !fifo_empty) begin
            pop     = 1'b1;
            shreg_n = fifo_rdata;
            state_n = ST_START;
            out_n   = LVL_LO;
          end
        end
        ST_START: begin
          state_n = ST_DATA;
          cnt_n   = BIT_FIRST;
          out_n   = shreg[15] ? LVL_HI : LVL_LO;
        end
        ST_DATA: begin
          if (cnt == 4'd0) begin
`ifdef BSG_MOD_PARITY_EN
            state_n = ST_PARITY;
            out_n   = (^shreg) ? LVL_HI : LVL_LO;
`else
            state_n = ST_STOP;
            out_n   = LVL_HI;
`endif
          end else begin
            cnt_n   = cnt - 4'd1;
            shreg_n = {shreg[14:0], shreg[15]};
            out_n   = shreg[14] ? LVL_HI : LVL_LO;
          end
        end
`ifdef BSG_MOD_PARITY_EN
        ST_PARITY: begin
          state_n = ST_STOP;
          out_n   = LVL_HI;
        end
`endif
        ST_STOP: begin
          frame_done = 1'b1;
          if (tx_en && !fifo_empty) begin
            pop     = 1'b1;
            shreg_n = fifo_rdata;
            state_n = ST_START;
            out_n   = LVL_LO;
          end else begin
            state_n = ST_IDLE;
            out_n   = MIDSCALE;
          end
        end
        default: begin
          state_n = ST_IDLE;
          out_n   = MIDSCALE;
        end
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge SYS_CLK) begin
    if (reset) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt   <= '0;
      out   <= MIDSCALE;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
      out   <= out_n;
    end
  end

  // Frame-complete flag; a set in the same cycle as a clear wins.
  always_ff @(posedge SYS_CLK) begin
    if (reset)           int_flag <= 1'b0;
    else if (frame_done) int_flag <= 1'b1;
    else if (int_clr)    int_flag <= 1'b0;
  end

endmodule

// File: doc/bsg_modulator.md
BSG_MODULATOR -- requirements
Module: bsg_modulator

Interface
REQ-001 Parameter AMP, default 8'd100, symbol amplitude offset from midscale; legal range 1..127.
REQ-002 Parameter FIFO_DEPTH, default 2, input word buffer depth; legal values 2 and 4.
REQ-003 SYS_CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tx_en  input  1  transmit enable (TXENABLE control bit).
REQ-006 tx_tick  input  1  one-SYS_CLK-wide symbol-rate strobe.
REQ-007 data_in  input  16  payload word {DATA_2, DATA_1}.
REQ-008 valid  input  1  data_in is valid.
REQ-009 ready  output  1  buffer can accept a word.
REQ-010 int_mask  input  1  1 = interrupt masked (INTMSK).
REQ-011 int_clr  input  1  one-cycle clear of int_flag.
REQ-012 out  output  8  unsigned modulated sample level.
REQ-013 int_flag  output  1  frame-complete flag (INTFLAG).
REQ-014 irq  output  1  int_flag & ~int_mask.
REQ-015 busy  output  1  1 while FSM is not IDLE (STATUS).

Function
REQ-016 A word SHALL be written into the FIFO on a cycle with valid & ready; ready = FIFO not full, combinational from FIFO count only.
REQ-017 A push while full SHALL be impossible, since ready is low; valid with ready low SHALL leave the FIFO unchanged.
REQ-018 FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-019 IDLE->START on tx_tick when tx_en=1 and the FIFO is non-empty; the head word SHALL be popped into a 16-bit shift register on that cycle.
REQ-020 START SHALL emit symbol 0; DATA SHALL emit bits 15 down to 0, MSB first, using a 4-bit bit counter; STOP SHALL emit symbol 1.
REQ-021 Every state SHALL advance only on tx_tick; each symbol lasts exactly one tx_tick period.
REQ-022 out SHALL be registered: symbol 1 = 8'h80+AMP, symbol 0 = 8'h80-AMP, IDLE = 8'h80; out changes on the cycle after the tick that enters the state.
REQ-023 On the tick that ends STOP: if tx_en=1 and the FIFO is non-empty, the FSM SHALL pop and enter START directly (back-to-back frames, no idle symbol); otherwise it SHALL enter IDLE.
REQ-024 Deasserting tx_en mid-frame SHALL NOT abort the frame; the current frame completes and no new frame starts.
REQ-025 A push and a pop in the same cycle SHALL leave the FIFO count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-026 int_flag SHALL set on the tick that ends STOP; int_clr SHALL clear it; simultaneous set and clear SHALL leave it set.
REQ-027 A frame without parity SHALL be 18 ticks: 1 start, 16 data, 1 stop.

Reset
REQ-028 reset SHALL force: FSM=IDLE, FIFO empty, shift register=0, bit counter=0, out=8'h80, int_flag=0, busy=0; ready=1 the cycle after reset deasserts.
REQ-029 reset asserted mid-frame SHALL discard the frame and buffered words, with no int_flag set.

Configuration
REQ-030 With BSG_MOD_PARITY_EN defined, PARITY SHALL follow DATA and emit the even-parity bit (XOR of the 16 payload bits), giving a 19-tick frame.
REQ-031 Without BSG_MOD_PARITY_EN, PARITY and its logic SHALL be absent and DATA SHALL go directly to STOP.

Structure
REQ-032 Package bsg_pkg SHALL hold the FSM state enum typedef, MIDSCALE=8'h80, and the frame-length constants.
REQ-033 The FIFO SHALL be one sub-module, bsg_word_fifo (parameters WIDTH=16, DEPTH); all other logic stays in bsg_modulator.

Verification
REQ-034 tx_en=1, push 16'hA5C3, tick every 4 cycles -> out sequence 0x1C, then bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 as 0xE4/0x1C, then 0xE4; int_flag set after tick 18; busy low afterwards.
REQ-035 Push 3 words with FIFO_DEPTH=2 and tx_en=0 -> ready low after 2 pushes, 3rd word held by the source; tx_en=1 -> two back-to-back 18-tick frames with no 0x80 gap.
REQ-036 int_mask=1, one frame -> int_flag=1, irq=0; clear int_mask -> irq=1; int_clr on the same cycle as a new frame end -> int_flag stays 1.
REQ-037 reset asserted at tick 7 of a frame -> next cycle out=0x80, busy=0, ready=1, int_flag=0; no further symbols.
REQ-038 BSG_MOD_PARITY_EN defined, payload 16'h0001 -> parity symbol 0xE4 at tick 18, stop at tick 19, int_flag after tick 19.
REQ-039 tx_en dropped at tick 5 with a second word queued -> first frame completes, FSM goes to IDLE, second word stays buffered, ready=1.
